// File: rtl/fft_result_streamer_pkg.sv
// ============================================================================
// fft_result_streamer_pkg : shared constants and FSM state type
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_result_streamer_pkg;

    localparam int FFT_N     = 8;
    localparam int FFT_LOG2N = 3;
    localparam int IFFT_RND  = 4;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/fft_post_scale.sv
// ============================================================================
// fft_post_scale : combinational conj/scale/round/saturate of one complex sample
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_post_scale
    import fft_result_streamer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              mode_i,
    input  logic [DATA_W-1:0] re_i,
    input  logic [DATA_W-1:0] im_i,
    output logic [DATA_W-1:0] re_o,
    output logic [DATA_W-1:0] im_o
);

    localparam logic signed [DATA_W:0] C_RND     = (DATA_W+1)'(IFFT_RND);
    localparam logic signed [DATA_W:0] C_SAT_MAX = {2'b00, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W:0] C_SAT_MIN = {2'b11, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W:0] w_re_sum;
    logic signed [DATA_W:0] w_im_sum;
    logic signed [DATA_W:0] w_re_shr;
    logic signed [DATA_W:0] w_im_shr;

    function automatic logic [DATA_W-1:0] sat(input logic signed [DATA_W:0] v);
        if (v > C_SAT_MAX)      sat = C_SAT_MAX[DATA_W-1:0];
        else if (v < C_SAT_MIN) sat = C_SAT_MIN[DATA_W-1:0];
        else                    sat = v[DATA_W-1:0];
    endfunction

    // One guard bit keeps -(-2^(DW-1)) and the rounding add exact before the shift.
    assign w_re_sum = {re_i[DATA_W-1], re_i} + C_RND;
    assign w_im_sum = C_RND - {im_i[DATA_W-1], im_i};
    assign w_re_shr = w_re_sum >>> FFT_LOG2N;
    assign w_im_shr = w_im_sum >>> FFT_LOG2N;

    assign re_o = mode_i ? sat(w_re_shr) : re_i;
    assign im_o = mode_i ? sat(w_im_shr) : im_i;

endmodule

`default_nettype wire

// File: rtl/fft_result_streamer.sv
// ============================================================================
// fft_result_streamer : captures 8 FFT bins and streams them over valid/ready
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_result_streamer
    import fft_result_streamer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_PTS  = FFT_N
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    bf_valid,
    input  logic                    ifft_mode,
    input  logic [N_PTS*DATA_W-1:0] in_real,
    input  logic [N_PTS*DATA_W-1:0] in_imag,
    input  logic                    clr_ovr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_real,
    output logic [DATA_W-1:0]       out_imag,
    output logic [FFT_LOG2N-1:0]    out_idx,
    output logic                    out_last,
    output logic                    busy,
    output logic                    overrun
);

    localparam int IDX_W = FFT_LOG2N;
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(N_PTS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               last_q, last_d;
    logic [DATA_W-1:0]  re_q, re_d;
    logic [DATA_W-1:0]  im_q, im_d;
    logic               mode_q, mode_d;
    logic               ovr_q, ovr_d;

    logic [DATA_W-1:0]  buf_re_q [N_PTS];
    logic [DATA_W-1:0]  buf_im_q [N_PTS];

    logic               w_accept;
    logic               w_last_acc;
    logic               w_capture;
    logic               w_drop;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               w_src_mode;
    logic [DATA_W-1:0]  w_src_re;
    logic [DATA_W-1:0]  w_src_im;
    logic [DATA_W-1:0]  w_scl_re;
    logic [DATA_W-1:0]  w_scl_im;

    assign w_accept   = (state_q == ST_STREAM) && out_ready;
    assign w_last_acc = w_accept && (idx_q == C_IDX_LAST);
    assign w_capture  = bf_valid && ((state_q == ST_IDLE) || w_last_acc);
    assign w_drop     = bf_valid && (state_q == ST_STREAM) && !w_last_acc;
    assign w_idx_nxt  = idx_q + 1'b1;

    // A fresh capture bypasses the buffer so bin 0 is on the outputs one cycle later.
    assign w_src_mode = w_capture ? ifft_mode               : mode_q;
    assign w_src_re   = w_capture ? in_real[0 +: DATA_W]    : buf_re_q[w_idx_nxt];
    assign w_src_im   = w_capture ? in_imag[0 +: DATA_W]    : buf_im_q[w_idx_nxt];

    fft_post_scale #(
        .DATA_W (DATA_W)
    ) u_post_scale (
        .mode_i (w_src_mode),
        .re_i   (w_src_re),
        .im_i   (w_src_im),
        .re_o   (w_scl_re),
        .im_o   (w_scl_im)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        re_d    = re_q;
        im_d    = im_q;
        mode_d  = mode_q;
        if (w_capture) begin
            state_d = ST_STREAM;
            idx_d   = '0;
            last_d  = 1'b0;
            re_d    = w_scl_re;
            im_d    = w_scl_im;
            mode_d  = ifft_mode;
        end else if (w_last_acc) begin
            state_d = ST_IDLE;
        end else if (w_accept) begin
            idx_d   = w_idx_nxt;
            last_d  = (w_idx_nxt == C_IDX_LAST);
            re_d    = w_scl_re;
            im_d    = w_scl_im;
        end
    end

    // Set wins over a simultaneous clear.
    assign ovr_d = w_drop ? 1'b1 : (clr_ovr ? 1'b0 : ovr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            last_q  <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
            mode_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            re_q    <= re_d;
            im_q    <= im_d;
            mode_q  <= mode_d;
            ovr_q   <= ovr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int k = 0; k < N_PTS; k++) begin
                buf_re_q[k] <= in_real[k*DATA_W +: DATA_W];
                buf_im_q[k] <= in_imag[k*DATA_W +: DATA_W];
            end
        end
    end

    assign out_valid = (state_q == ST_STREAM);
    assign busy      = (state_q == ST_STREAM);
    assign out_real  = re_q;
    assign out_imag  = im_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;
    assign overrun   = ovr_q;

endmodule

`default_nettype wire
